gpio_apb_sequencer: RTL and testbench

APB master that brings up a CoreGPIO instance and then services it at run time. After reset it writes every per-IO CONFIG register and the initial output word. It then arbitrates between interrupt servicing (read INT, write-1-clear) and user output-update requests. It sits between local control logic and the CoreGPIO APB slave port, replacing the BFM/processor master on the GPIO APB segment.

---
 rtl/gpio_apb_sequencer.sv | 168 ++++++++++++++++
 tb/tb_gpio_apb_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_apb_sequencer.sv
// APB master that configures a CoreGPIO instance, then services its interrupts and output-word updates.
// Latency: each transfer takes 3 cycles with no wait states; bring-up completes 3*(IO_NUM+1) cycles after reset.
// Backpressure: PREADY low holds ACCESS with address/data stable; IDLE requests wait until the current transfer completes.
module gpio_apb_sequencer #(
    parameter int               IO_NUM    = 8,
    parameter int               APB_WIDTH = 32,
    parameter logic [7:0]       CFG_WORD  = 8'h0F,
    parameter logic [IO_NUM-1:0] OUT_INIT = '0
) (
    input  logic                 PCLK,
    input  logic                 PRESETN,
    output logic [7:0]           PADDR,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [APB_WIDTH-1:0] PWDATA,
    input  logic [APB_WIDTH-1:0] PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR,
    input  logic                 INT_OR,
    input  logic                 out_req,
    input  logic [IO_NUM-1:0]    out_data,
    output logic                 out_ack,
    output logic                 irq_valid,
    output logic [IO_NUM-1:0]    irq_vec,
    output logic                 init_done,
    output logic                 err
);

    localparam logic [2:0] ST_CFG     = 3'd0;
    localparam logic [2:0] ST_OUTI    = 3'd1;
    localparam logic [2:0] ST_IDLE    = 3'd2;
    localparam logic [2:0] ST_IRQ_RD  = 3'd3;
    localparam logic [2:0] ST_IRQ_CLR = 3'd4;
    localparam logic [2:0] ST_OUT_WR  = 3'd5;

    localparam logic [7:0] ADDR_INT = 8'h80;
    localparam logic [7:0] ADDR_OUT = 8'hA0;
    localparam logic [4:0] LAST_IDX = 5'(IO_NUM - 1);

    logic [2:0]        state;
    logic [4:0]        idx;
    logic [IO_NUM-1:0] out_lat;

    logic [7:0]  setup_addr;
    logic        setup_write;
    logic [31:0] setup_wdata;
    logic [31:0] prdata_ext;
    logic        unused_bits;

    // Zero-extend read data so IO_NUM may exceed the bus width without out-of-range slices
    always_comb begin
        prdata_ext = '0;
        prdata_ext[APB_WIDTH-1:0] = PRDATA;
    end

    assign unused_bits = ^{prdata_ext, setup_wdata};

    // Address, direction and data the current state presents in its SETUP cycle
    always_comb begin
        setup_addr  = '0;
        setup_write = 1'b0;
        setup_wdata = '0;
        case (state)
            ST_CFG: begin
                setup_addr       = {1'b0, idx, 2'b00};
                setup_write      = 1'b1;
                setup_wdata[7:0] = CFG_WORD;
            end
            ST_OUTI: begin
                setup_addr                = ADDR_OUT;
                setup_write               = 1'b1;
                setup_wdata[IO_NUM-1:0]   = OUT_INIT;
            end
            ST_IRQ_RD: begin
                setup_addr  = ADDR_INT;
                setup_write = 1'b0;
            end
            ST_IRQ_CLR: begin
                setup_addr              = ADDR_INT;
                setup_write             = 1'b1;
                setup_wdata[IO_NUM-1:0] = irq_vec;
            end
            ST_OUT_WR: begin
                setup_addr              = ADDR_OUT;
                setup_write             = 1'b1;
                setup_wdata[IO_NUM-1:0] = out_lat;
            end
            default: begin
                setup_addr  = '0;
                setup_write = 1'b0;
            end
        endcase
    end

    // Sequencer plus APB phase tracking: SETUP, ACCESS until PREADY, then one idle gap
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state     <= ST_CFG;
            idx       <= '0;
            out_lat   <= '0;
            PADDR     <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            out_ack   <= 1'b0;
            irq_valid <= 1'b0;
            irq_vec   <= '0;
            init_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_ack   <= 1'b0;
            irq_valid <= 1'b0;
            if (state == ST_IDLE) begin
                // Interrupts win over output updates
                if (INT_OR) begin
                    state <= ST_IRQ_RD;
                end else if (out_req) begin
                    state   <= ST_OUT_WR;
                    out_lat <= out_data;
                end
            end else if (!PSEL) begin
                PSEL   <= 1'b1;
                PADDR  <= setup_addr;
                PWRITE <= setup_write;
                PWDATA <= setup_wdata[APB_WIDTH-1:0];
            end else if (!PENABLE) begin
                PENABLE <= 1'b1;
            end else if (PREADY) begin
                PSEL    <= 1'b0;
                PENABLE <= 1'b0;
                if (PSLVERR) begin
                    err <= 1'b1;
                end
                case (state)
                    ST_CFG: begin
                        if (idx == LAST_IDX) begin
                            state <= ST_OUTI;
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
                    ST_OUTI: begin
                        state     <= ST_IDLE;
                        init_done <= 1'b1;
                    end
                    ST_IRQ_RD: begin
                        irq_vec <= prdata_ext[IO_NUM-1:0];
                        state   <= ST_IRQ_CLR;
                    end
                    ST_IRQ_CLR: begin
                        irq_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end
                    ST_OUT_WR: begin
                        out_ack <= 1'b1;
                        state   <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gpio_apb_sequencer.sv
`timescale 1ns/1ps
module tb_gpio_apb_sequencer;

    localparam int               IO_NUM    = 8;
    localparam int               APB_WIDTH = 32;
    localparam logic [7:0]       CFG_WORD  = 8'h0F;
    localparam logic [IO_NUM-1:0] OUT_INIT = 8'h5A;

    logic                 PCLK = 1'b0;
    logic                 PRESETN = 1'b0;
    logic [7:0]           PADDR;
    logic                 PSEL, PENABLE, PWRITE;
    logic [APB_WIDTH-1:0] PWDATA;
    logic [APB_WIDTH-1:0] PRDATA;
    logic                 PREADY, PSLVERR, INT_OR;
    logic                 out_req;
    logic [IO_NUM-1:0]    out_data;
    logic                 out_ack, irq_valid;
    logic [IO_NUM-1:0]    irq_vec;
    logic                 init_done, err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed { logic [7:0] addr; logic wr; logic [31:0] data; } xfer_t;
    typedef struct packed { logic is_irq; logic [7:0] val; } evt_t;
    xfer_t exp_x[$];
    evt_t  exp_e[$];

    // Slave-side model state
    logic [7:0]  int_reg;
    logic        int_force;
    logic        rand_wait;
    logic [7:0]  stall_addr;
    logic        stall_arm;
    int          stall_left;
    logic        err_arm;
    logic [7:0]  err_addr;
    logic [31:0] rnd;

    // Monitor tracking
    logic        in_xfer;
    logic        gap_due;
    logic [7:0]  s_addr;
    logic        s_wr;
    logic [31:0] s_data;
    xfer_t       cur_x;
    evt_t        cur_e;

    assign INT_OR = (|int_reg) | int_force;

    gpio_apb_sequencer #(
        .IO_NUM(IO_NUM), .APB_WIDTH(APB_WIDTH), .CFG_WORD(CFG_WORD), .OUT_INIT(OUT_INIT)
    ) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .INT_OR(INT_OR), .out_req(out_req), .out_data(out_data), .out_ack(out_ack),
        .irq_valid(irq_valid), .irq_vec(irq_vec), .init_done(init_done), .err(err)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_x(input logic [7:0] a, input logic w, input logic [31:0] d);
        xfer_t x;
        x.addr = a; x.wr = w; x.data = d;
        exp_x.push_back(x);
    endtask

    task automatic push_e(input logic is_irq, input logic [7:0] v);
        evt_t e;
        e.is_irq = is_irq; e.val = v;
        exp_e.push_back(e);
    endtask

    // Bring-up as the register map dictates: one CONFIG write per IO, then the initial output word
    task automatic push_bringup();
        for (int i = 0; i < IO_NUM; i++) push_x(8'(4 * i), 1'b1, 32'(CFG_WORD));
        push_x(8'hA0, 1'b1, 32'(OUT_INIT));
    endtask

    task automatic measure_init(input int required, input string name);
        int n;
        n = 0;
        while (!init_done && n < 400) begin
            @(negedge PCLK);
            n++;
        end
        check(name, n, required);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_x.size() != 0 || exp_e.size() != 0) && n < 3000) begin
            @(negedge PCLK);
            n++;
        end
        check("drain_pending_xfers", exp_x.size(), 0);
        check("drain_pending_events", exp_e.size(), 0);
    endtask

    task automatic hold_reset();
        PRESETN = 1'b0;
        exp_x.delete();
        exp_e.delete();
        out_req = 1'b0;
        repeat (2) @(negedge PCLK);
    endtask

    // APB slave model and scoreboard monitor; runs mid-cycle away from the active edge
    always @(negedge PCLK) begin
        if (!PRESETN) begin
            in_xfer    = 1'b0;
            gap_due    = 1'b0;
            stall_left = 0;
            PREADY     = 1'b1;
            PSLVERR    = 1'b0;
        end else begin
            if (gap_due) check("gap_after_completion", PSEL, 1'b0);
            gap_due = 1'b0;
            if (PSEL && !PENABLE) begin
                check("setup_not_repeated", in_xfer, 1'b0);
                in_xfer = 1'b1;
                s_addr  = PADDR;
                s_wr    = PWRITE;
                s_data  = PWDATA;
                if (stall_arm && PADDR == stall_addr) begin
                    stall_left = 3;
                    stall_arm  = 1'b0;
                end
                PREADY  = 1'b1;
                PSLVERR = 1'b0;
            end else if (PSEL && PENABLE) begin
                check("access_has_setup", in_xfer, 1'b1);
                check("access_addr_dir_stable", {PADDR, PWRITE}, {s_addr, s_wr});
                check("access_wdata_stable", PWDATA, s_data);
                if (stall_left > 0) begin
                    PREADY = 1'b0;
                    stall_left--;
                end else begin
                    PREADY = rand_wait ? ($urandom_range(0, 2) != 0) : 1'b1;
                end
                PSLVERR = 1'b0;
                if (PREADY) begin
                    if (exp_x.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_xfer: got addr 0x%0h wr %0d required none", PADDR, PWRITE);
                    end else begin
                        cur_x = exp_x.pop_front();
                        check("xfer_addr", PADDR, cur_x.addr);
                        check("xfer_dir", PWRITE, cur_x.wr);
                        if (cur_x.wr) check("xfer_wdata", PWDATA, cur_x.data);
                    end
                    if (err_arm && PADDR == err_addr) begin
                        PSLVERR = 1'b1;
                        err_arm = 1'b0;
                    end
                    if (PADDR == 8'h80) begin
                        if (!PWRITE) begin
                            rnd       = $urandom();
                            PRDATA    = {rnd[31:8], int_reg};
                            int_force = 1'b0;
                        end else begin
                            int_reg = int_reg & ~PWDATA[7:0];
                        end
                    end
                    in_xfer = 1'b0;
                    gap_due = 1'b1;
                end
            end
            if (irq_valid || out_ack) begin
                if (exp_e.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got irq_valid %0d out_ack %0d required none", irq_valid, out_ack);
                end else begin
                    cur_e = exp_e.pop_front();
                    check("event_kind_irq", irq_valid, cur_e.is_irq);
                    check("event_kind_ack", out_ack, !cur_e.is_irq);
                    if (cur_e.is_irq) check("irq_vec", irq_vec, cur_e.val);
                end
            end
        end
    end

    initial begin
        int          kind;
        logic [7:0]  v;
        logic [7:0]  d;
        int          need;
        int          acks;
        int          n;

        PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
        out_req = 1'b0; out_data = '0;
        int_reg = '0; int_force = 1'b0; rand_wait = 1'b0;
        stall_addr = '0; stall_arm = 1'b0; stall_left = 0;
        err_arm = 1'b0; err_addr = '0;
        in_xfer = 1'b0; gap_due = 1'b0;

        PRESETN = 1'b0;
        repeat (3) @(negedge PCLK);
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_pwrite", PWRITE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_out_ack", out_ack, 0);
        check("rst_irq_valid", irq_valid, 0);
        check("rst_irq_vec", irq_vec, 0);
        check("rst_init_done", init_done, 0);
        check("rst_err", err, 0);

        // Plain bring-up with zero wait states
        push_bringup();
        PRESETN = 1'b1;
        measure_init(3 * (IO_NUM + 1), "init_latency_nowait");
        wait_drain();
        check("err_clean_bringup", err, 0);

        // Bring-up with three wait states on CONFIG_2
        hold_reset();
        stall_addr = 8'h08;
        stall_arm  = 1'b1;
        push_bringup();
        PRESETN = 1'b1;
        measure_init(3 * (IO_NUM + 1) + 3, "init_latency_stall");
        wait_drain();

        // Slave error on the initial output write does not stop bring-up
        hold_reset();
        err_arm  = 1'b1;
        err_addr = 8'hA0;
        push_bringup();
        PRESETN = 1'b1;
        measure_init(3 * (IO_NUM + 1), "init_latency_slverr");
        wait_drain();
        check("err_after_slverr", err, 1);
        check("init_done_after_slverr", init_done, 1);

        // Directed interrupt and output cases from the plan, then randomized traffic
        rand_wait = 1'b1;
        for (int it = 0; it < 40; it++) begin
            if (it == 0) begin
                kind = 0; v = 8'h24; d = 8'h00;
            end else if (it == 1) begin
                kind = 1; v = 8'h00; d = 8'hA5;
            end else if (it == 2) begin
                kind = 2; v = 8'h81; d = 8'h3C;
            end else if (it == 3) begin
                kind = 0; v = 8'h00; d = 8'h00;
            end else begin
                kind = $urandom_range(0, 3);
                v    = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom());
                d    = 8'($urandom());
            end
            if (kind == 0 || kind == 2) begin
                push_x(8'h80, 1'b0, 32'(v));
                push_x(8'h80, 1'b1, 32'(v));
                push_e(1'b1, v);
            end
            need = 0;
            if (kind == 1 || kind == 2) need = 1;
            if (kind == 3) need = 2;
            for (int k = 0; k < need; k++) begin
                push_x(8'hA0, 1'b1, 32'(d));
                push_e(1'b0, 8'h00);
            end
            @(negedge PCLK);
            if (kind == 0 || kind == 2) begin
                if (v == 8'h00) int_force = 1'b1;
                else int_reg = v;
            end
            if (need > 0) begin
                out_req  = 1'b1;
                out_data = d;
                acks = 0;
                n    = 0;
                while (acks < need && n < 1000) begin
                    @(negedge PCLK);
                    n++;
                    if (out_ack) acks++;
                end
                out_req = 1'b0;
            end
            wait_drain();
            repeat ($urandom_range(1, 4)) @(negedge PCLK);
        end
        check("err_sticky", err, 1);
        check("irq_line_cleared", INT_OR, 0);

        // Reset in the middle of an ACCESS phase restarts bring-up
        stall_addr = 8'hA0;
        stall_arm  = 1'b1;
        out_data   = 8'h77;
        out_req    = 1'b1;
        n = 0;
        while (!(PSEL && PENABLE) && n < 200) begin
            @(negedge PCLK);
            n++;
        end
        check("reached_access_for_reset", {PSEL, PENABLE}, 2'b11);
        #1;
        PRESETN = 1'b0;
        #1;
        check("midreset_psel", PSEL, 0);
        check("midreset_penable", PENABLE, 0);
        check("midreset_err", err, 0);
        check("midreset_init_done", init_done, 0);
        stall_arm = 1'b0;
        rand_wait = 1'b0;
        hold_reset();
        push_bringup();
        PRESETN = 1'b1;
        measure_init(3 * (IO_NUM + 1), "init_latency_after_midreset");
        wait_drain();
        check("err_after_restart", err, 0);

        repeat (3) @(negedge PCLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
